// File: rtl/exec_alu.sv
// exec_alu -- single-cycle RV32I integer/branch execution unit.
//
// Sits between the reservation station and the reorder buffer. Each cycle it
// may accept one decoded op whose operands are ready. One clock later it
// returns the result, the rob tag (the instruction pc) and the next pc.
// Loads and stores are handled elsewhere and never reach this unit.
//
// Ports
//   clk               in   clock, all state on the rising edge
//   rst               in   synchronous reset, active-low
//   is_empty_from_rs  in   1 = no op this cycle
//   op_from_rs        in   internal opcode (0 NOP .. 29 AND)
//   v1_from_rs        in   rs1 value
//   v2_from_rs        in   rs2 value
//   imm_from_rs       in   sign-extended immediate (LUI/AUIPC already <<12)
//   pc_from_rs        in   instruction pc, also the rob tag
//   is_finish_to_rob  out  result valid this cycle
//   data_to_rob       out  rd write value, or branch-taken flag
//   pc_to_rob         out  rob tag
//   jpc_to_rob        out  next pc of the instruction
//   is_illegal_to_rob out  finishing op had an unlisted opcode
//                          (only when ALU_ILLEGAL_FLAG_EN is defined)
//
// Build option: ALU_ILLEGAL_FLAG_EN adds is_illegal_to_rob. Without it,
// unlisted opcodes simply behave as NOP.
//
// The datapath assumes DATA_W == PC_W (RV32I: both 32).

module exec_alu #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_empty_from_rs,
  input  logic [OP_W-1:0]   op_from_rs,
  input  logic [DATA_W-1:0] v1_from_rs,
  input  logic [DATA_W-1:0] v2_from_rs,
  input  logic [DATA_W-1:0] imm_from_rs,
  input  logic [PC_W-1:0]   pc_from_rs,
  output logic              is_finish_to_rob,
  output logic [DATA_W-1:0] data_to_rob,
  output logic [PC_W-1:0]   pc_to_rob,
  output logic [PC_W-1:0]   jpc_to_rob
`ifdef ALU_ILLEGAL_FLAG_EN
  ,
  output logic              is_illegal_to_rob
`endif
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(22);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(25);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(26);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(27);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(28);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(29);

  logic [DATA_W-1:0] v1;
  logic [DATA_W-1:0] v2;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_plus4;
  logic [PC_W-1:0]   pc_plus_imm;
  logic [DATA_W-1:0] res_data;
  logic [PC_W-1:0]   res_jpc;
  logic              res_illegal;
  logic              taken;
  logic              eq;
  logic              lt_s;
  logic              lt_u;

  assign v1          = v1_from_rs;
  assign v2          = v2_from_rs;
  assign imm         = imm_from_rs;
  assign pc          = pc_from_rs;
  assign pc_plus4    = pc + PC_W'(4);
  assign pc_plus_imm = pc + PC_W'(imm);

  // Branch comparators are shared by the six branch opcodes.
  assign eq   = (v1 == v2);
  assign lt_s = ($signed(v1) < $signed(v2));
  assign lt_u = (v1 < v2);

  always_comb begin
    taken = 1'b0;
    unique case (op_from_rs)
      OP_BEQ:  taken = eq;
      OP_BNE:  taken = !eq;
      OP_BLT:  taken = lt_s;
      OP_BGE:  taken = !lt_s;
      OP_BLTU: taken = lt_u;
      OP_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    res_data    = '0;
    res_jpc     = pc_plus4;
    res_illegal = 1'b0;
    case (op_from_rs)
      OP_NOP:   res_data = '0;
      OP_LUI:   res_data = imm;
      OP_AUIPC: res_data = DATA_W'(pc_plus_imm);
      OP_JAL: begin
        res_data = DATA_W'(pc_plus4);
        res_jpc  = pc_plus_imm;
      end
      OP_JALR: begin
        res_data = DATA_W'(pc_plus4);
        // Target LSB is forced to zero, as RV32I requires.
        res_jpc  = PC_W'(v1 + imm) & ~PC_W'(1);
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res_data = DATA_W'(taken);
        res_jpc  = taken ? pc_plus_imm : pc_plus4;
      end
      OP_ADDI:  res_data = v1 + imm;
      OP_SLTI:  res_data = DATA_W'($signed(v1) < $signed(imm));
      OP_SLTIU: res_data = DATA_W'(v1 < imm);
      OP_XORI:  res_data = v1 ^ imm;
      OP_ORI:   res_data = v1 | imm;
      OP_ANDI:  res_data = v1 & imm;
      OP_SLLI:  res_data = v1 << imm[SH_W-1:0];
      OP_SRLI:  res_data = v1 >> imm[SH_W-1:0];
      OP_SRAI:  res_data = DATA_W'($signed(v1) >>> imm[SH_W-1:0]);
      OP_ADD:   res_data = v1 + v2;
      OP_SUB:   res_data = v1 - v2;
      OP_SLL:   res_data = v1 << v2[SH_W-1:0];
      OP_SLT:   res_data = DATA_W'(lt_s);
      OP_SLTU:  res_data = DATA_W'(lt_u);
      OP_XOR:   res_data = v1 ^ v2;
      OP_SRL:   res_data = v1 >> v2[SH_W-1:0];
      OP_SRA:   res_data = DATA_W'($signed(v1) >>> v2[SH_W-1:0]);
      OP_OR:    res_data = v1 | v2;
      OP_AND:   res_data = v1 & v2;
      // Unlisted opcodes complete like a NOP so the rob never stalls.
      default:  res_illegal = 1'b1;
    endcase
  end

  // data/pc/jpc only load on a real op; on idle cycles they hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      is_finish_to_rob <= 1'b0;
      data_to_rob      <= '0;
      pc_to_rob        <= '0;
      jpc_to_rob       <= '0;
    end else if (!is_empty_from_rs) begin
      is_finish_to_rob <= 1'b1;
      data_to_rob      <= res_data;
      pc_to_rob        <= pc;
      jpc_to_rob       <= res_jpc;
    end else begin
      is_finish_to_rob <= 1'b0;
    end
  end

`ifdef ALU_ILLEGAL_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      is_illegal_to_rob <= 1'b0;
    end else if (!is_empty_from_rs) begin
      is_illegal_to_rob <= res_illegal;
    end else begin
      is_illegal_to_rob <= 1'b0;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = res_illegal;
`endif

endmodule

// File: tb/tb_exec_alu.sv
// Self-checking bench for exec_alu: directed vector table, hand-written
// multi-cycle sequences, and random ops checked against a reference model.
module tb_exec_alu;

  logic        clk;
  logic        rst;
  logic        is_empty_from_rs;
  logic [5:0]  op_from_rs;
  logic [31:0] v1_from_rs;
  logic [31:0] v2_from_rs;
  logic [31:0] imm_from_rs;
  logic [31:0] pc_from_rs;
  logic        is_finish_to_rob;
  logic [31:0] data_to_rob;
  logic [31:0] pc_to_rob;
  logic [31:0] jpc_to_rob;
`ifdef ALU_ILLEGAL_FLAG_EN
  logic        is_illegal_to_rob;
`endif

  int checks = 0;
  int failures = 0;

  exec_alu #(.DATA_W(32), .PC_W(32), .OP_W(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .is_empty_from_rs (is_empty_from_rs),
    .op_from_rs       (op_from_rs),
    .v1_from_rs       (v1_from_rs),
    .v2_from_rs       (v2_from_rs),
    .imm_from_rs      (imm_from_rs),
    .pc_from_rs       (pc_from_rs),
    .is_finish_to_rob (is_finish_to_rob),
    .data_to_rob      (data_to_rob),
    .pc_to_rob        (pc_to_rob),
    .jpc_to_rob       (jpc_to_rob)
`ifdef ALU_ILLEGAL_FLAG_EN
    ,
    .is_illegal_to_rob(is_illegal_to_rob)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] exp_data;
    logic [31:0] exp_jpc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present one cycle of input, let the edge capture it, then settle.
  task automatic drive(input logic empty, input logic [5:0] op, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] imm, input logic [31:0] pc);
    is_empty_from_rs = empty;
    op_from_rs       = op;
    v1_from_rs       = v1;
    v2_from_rs       = v2;
    imm_from_rs      = imm;
    pc_from_rs       = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_op(input string name, input logic [5:0] op, input logic [31:0] pc,
                          input logic [31:0] exp_data, input logic [31:0] exp_jpc);
    check({name, ".finish"}, {31'd0, is_finish_to_rob}, 32'd1);
    check({name, ".data"}, data_to_rob, exp_data);
    check({name, ".pc"}, pc_to_rob, pc);
    check({name, ".jpc"}, jpc_to_rob, exp_jpc);
`ifdef ALU_ILLEGAL_FLAG_EN
    check({name, ".illegal"}, {31'd0, is_illegal_to_rob}, {31'd0, (op > 6'd29)});
`else
    if (op > 6'd63) check({name, ".op"}, {26'd0, op}, 32'd0);
`endif
  endtask

  // Reference: RV32I semantics written directly from the opcode list.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [31:0] pc,
                                output logic [31:0] d, output logic [31:0] j);
    longint sa;
    logic [31:0] rhs;
    int sh;
    bit is_branch;
    bit tk;
    d = 32'd0;
    j = pc + 32'd4;
    sa = longint'($signed(a));
    rhs = (op >= 6'd20) ? b : imm;
    sh = int'(rhs[4:0]);
    is_branch = (op >= 6'd5 && op <= 6'd10);
    tk = 1'b0;
    case (op)
      6'd5:  tk = (a == b);
      6'd6:  tk = (a != b);
      6'd7:  tk = (longint'($signed(a)) < longint'($signed(b)));
      6'd8:  tk = (longint'($signed(a)) >= longint'($signed(b)));
      6'd9:  tk = (longint'(a) < longint'(b));
      6'd10: tk = (longint'(a) >= longint'(b));
      default: tk = 1'b0;
    endcase
    if (is_branch) begin
      d = tk ? 32'd1 : 32'd0;
      if (tk) j = pc + imm;
    end else begin
      case (op)
        6'd1:  d = imm;
        6'd2:  d = pc + imm;
        6'd3:  begin d = pc + 32'd4; j = pc + imm; end
        6'd4:  begin d = pc + 32'd4; j = (a + imm) & 32'hFFFF_FFFE; end
        6'd11, 6'd20: d = a + rhs;
        6'd21: d = a - rhs;
        6'd12, 6'd23: d = (sa < longint'($signed(rhs))) ? 32'd1 : 32'd0;
        6'd13, 6'd24: d = (longint'(a) < longint'(rhs)) ? 32'd1 : 32'd0;
        6'd14, 6'd25: d = a ^ rhs;
        6'd15, 6'd28: d = a | rhs;
        6'd16, 6'd29: d = a & rhs;
        6'd17, 6'd22: d = 32'(longint'(a) * (64'd1 << sh));
        6'd18, 6'd26: d = 32'(longint'(a) / (64'd1 << sh));
        6'd19, 6'd27: d = 32'(sa >>> sh);
        default: d = 32'd0;
      endcase
    end
  endfunction

  initial begin
    logic [31:0] ed;
    logic [31:0] ej;
    logic [5:0]  rop;
    logic [31:0] ra, rb, ri, rp;

    vecs.push_back('{"addi_neg",  6'd11, 32'd5,        32'd0, 32'hFFFF_FFF9, 32'h100,  32'hFFFF_FFFE, 32'h104});
    vecs.push_back('{"blt_taken", 6'd7,  32'hFFFF_FFFF, 32'd1, 32'h20,       32'h200,  32'd1,         32'h220});
    vecs.push_back('{"bltu_nt",   6'd9,  32'hFFFF_FFFF, 32'd1, 32'h20,       32'h200,  32'd0,         32'h204});
    vecs.push_back('{"jalr",      6'd4,  32'h1001,     32'd0, 32'd2,        32'h40,   32'h44,        32'h1002});
    vecs.push_back('{"sra",       6'd27, 32'h8000_0000, 32'h24, 32'd0,      32'h300,  32'hF800_0000, 32'h304});
    vecs.push_back('{"srli",      6'd18, 32'h8000_0000, 32'd0, 32'd4,       32'h304,  32'h0800_0000, 32'h308});
    vecs.push_back('{"lui",       6'd1,  32'd7,        32'd9, 32'h1234_5000, 32'h10,  32'h1234_5000, 32'h14});
    vecs.push_back('{"auipc",     6'd2,  32'd0,        32'd0, 32'h2000,     32'h1000, 32'h3000,      32'h1004});
    vecs.push_back('{"jal_back",  6'd3,  32'd0,        32'd0, 32'hFFFF_FFF8, 32'h80,  32'h84,        32'h78});
    vecs.push_back('{"beq_taken", 6'd5,  32'd3,        32'd3, 32'h10,       32'h0,    32'd1,         32'h10});
    vecs.push_back('{"bge_nt",    6'd8,  32'hFFFF_FFFF, 32'd1, 32'h40,      32'h500,  32'd0,         32'h504});
    vecs.push_back('{"sub_wrap",  6'd21, 32'd3,        32'd5, 32'd0,        32'h600,  32'hFFFF_FFFE, 32'h604});
    vecs.push_back('{"sltiu",     6'd13, 32'd1,        32'd0, 32'hFFFF_FFFF, 32'h700, 32'd1,         32'h704});
    vecs.push_back('{"slt_neg",   6'd23, 32'hFFFF_FFFE, 32'd1, 32'd0,       32'h704,  32'd1,         32'h708});
    vecs.push_back('{"nop",       6'd0,  32'hAAAA,     32'hBBBB, 32'hCCCC,  32'h800,  32'd0,         32'h804});
    vecs.push_back('{"unlisted",  6'd35, 32'hAAAA,     32'hBBBB, 32'hCCCC,  32'h900,  32'd0,         32'h904});

    // Reset, then idle.
    rst = 1'b0;
    drive(1'b1, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    check("reset.finish", {31'd0, is_finish_to_rob}, 32'd0);
    check("reset.data", data_to_rob, 32'd0);
    check("reset.pc", pc_to_rob, 32'd0);
    check("reset.jpc", jpc_to_rob, 32'd0);
    rst = 1'b1;
    drive(1'b1, 6'd11, 32'd1, 32'd1, 32'd1, 32'h44);
    check("idle.finish", {31'd0, is_finish_to_rob}, 32'd0);

    // Directed table, applied back-to-back.
    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].op, vecs[i].v1, vecs[i].v2, vecs[i].imm, vecs[i].pc);
      check_op(vecs[i].name, vecs[i].op, vecs[i].pc, vecs[i].exp_data, vecs[i].exp_jpc);
    end
    drive(1'b1, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    check("table_end.finish", {31'd0, is_finish_to_rob}, 32'd0);

    // Three back-to-back ops, then idle.
    drive(1'b0, 6'd20, 32'd10, 32'd20, 32'd0, 32'h1000);
    check_op("b2b0", 6'd20, 32'h1000, 32'd30, 32'h1004);
    drive(1'b0, 6'd25, 32'hF0F0, 32'h0FF0, 32'd0, 32'h1004);
    check_op("b2b1", 6'd25, 32'h1004, 32'hFF00, 32'h1008);
    drive(1'b0, 6'd6, 32'd1, 32'd2, 32'h100, 32'h1008);
    check_op("b2b2", 6'd6, 32'h1008, 32'd1, 32'h1108);
    drive(1'b1, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    check("b2b_idle.finish", {31'd0, is_finish_to_rob}, 32'd0);
`ifdef ALU_ILLEGAL_FLAG_EN
    check("b2b_idle.illegal", {31'd0, is_illegal_to_rob}, 32'd0);
`endif

    // Reset wins over a presented op.
    drive(1'b0, 6'd11, 32'd1, 32'd0, 32'd1, 32'h2000);
    check_op("pre_rst", 6'd11, 32'h2000, 32'd2, 32'h2004);
    rst = 1'b0;
    drive(1'b0, 6'd11, 32'd5, 32'd0, 32'd5, 32'h2004);
    check("rst_op.finish", {31'd0, is_finish_to_rob}, 32'd0);
    check("rst_op.data", data_to_rob, 32'd0);
    check("rst_op.jpc", jpc_to_rob, 32'd0);
    rst = 1'b1;
    drive(1'b1, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    check("post_rst.finish", {31'd0, is_finish_to_rob}, 32'd0);

    // Random ops against the reference model, with occasional idles.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        drive(1'b1, 6'($urandom), $urandom, $urandom, $urandom, $urandom);
        check("rand_idle.finish", {31'd0, is_finish_to_rob}, 32'd0);
      end else begin
        rop = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(30, 63)) : 6'($urandom_range(0, 29));
        ra  = $urandom;
        rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
        ri  = $urandom;
        rp  = $urandom & 32'hFFFF_FFFC;
        model(rop, ra, rb, ri, rp, ed, ej);
        drive(1'b0, rop, ra, rb, ri, rp);
        check_op($sformatf("rand_op%0d", rop), rop, rp, ed, ej);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
